// File: rtl/uvme_obi_st_slv_mem_pkg.sv
// Shared types and helpers for the OBI self-test slave responder.
// A response entry is what the slave owes the master for one accepted request.
package uvme_obi_st_slv_mem_pkg;

    localparam int OBI_BE_WIDTH   = 4;
    localparam int OBI_DATA_WIDTH = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_entry_t;

    // Byte address to word index; the two low address bits never select a word.
    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/uvme_obi_st_slv_mem_rsp_fifo.sv
// In-order response queue between request acceptance and the rvalid/rready channel.
// count_o carries one extra bit so a full queue is distinguishable from an empty one.
module uvme_obi_st_slv_mem_rsp_fifo
    import uvme_obi_st_slv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  rsp_entry_t data_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // A simultaneous push and pop leaves occupancy unchanged.
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uvme_obi_st_slv_mem.sv
// OBI slave responder backed by a word-addressed memory for the OBI self-test link.
// Requests are granted while the response queue has room; responses return in order.
module uvme_obi_st_slv_mem
    import uvme_obi_st_slv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 256,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    output logic                    gnt,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [OBI_BE_WIDTH-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    input  logic                    gnt_stall,
    output logic [CW-1:0]           outstanding
);

    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [63:0]           word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  in_range;
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    rsp_entry_t            push_entry;
    rsp_entry_t            head_entry;

    assign word_idx = word_index(64'(addr));
    assign in_range = (word_idx < 64'(DEPTH_WORDS));
    assign mem_idx  = word_idx[MEM_AW-1:0];

    // No full-bypass: a pop in this cycle does not free a slot until the next one.
    assign gnt    = req && !reset && !gnt_stall && !fifo_full;
    assign accept = req && gnt;
    assign rvalid = !fifo_empty;
    assign pop    = rvalid && rready;

    always_comb begin
        push_entry.rdata = '0;
        push_entry.err   = !in_range;
        if (in_range && !we) begin
            push_entry.rdata = mem_q[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && we && in_range) begin
            for (int i = 0; i < OBI_BE_WIDTH; i++) begin
                if (be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    uvme_obi_st_slv_mem_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    // Outputs read as zero whenever no response is presented.
    assign rdata = rvalid ? head_entry.rdata : '0;
    assign err   = rvalid ? head_entry.err   : 1'b0;

endmodule

// File: tb/tb_uvme_obi_st_slv_mem.sv
// Self-checking bench: a queue-and-array model of the slave is checked every cycle,
// and directed scenarios pin literal response values.
module tb_uvme_obi_st_slv_mem;

    localparam int MAXO = 4;

    logic        clk;
    logic        reset;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;
    logic        gnt_stall;
    logic [2:0]  outstanding;

    int total = 0;
    int bad   = 0;

    logic [32:0] modelQ [$];
    logic [32:0] obsQ   [$];
    logic [31:0] mm     [int unsigned];

    bit          mAcc;
    bit          mPop;
    int unsigned mIdx;
    logic [31:0] mWord;

    uvme_obi_st_slv_mem #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .DEPTH_WORDS     (256),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .addr        (addr),
        .we          (we),
        .be          (be),
        .wdata       (wdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .err         (err),
        .gnt_stall   (gnt_stall),
        .outstanding (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the slave owes one {rdata,err} per accepted request, in acceptance order.
    always @(posedge clk) begin
        if (reset) begin
            modelQ.delete();
        end else begin
            mAcc = req && !gnt_stall && (modelQ.size() < MAXO);
            mPop = (modelQ.size() > 0) && rready;
            mIdx = addr >> 2;
            if (mPop) void'(modelQ.pop_front());
            if (mAcc) begin
                if (mIdx >= 256) begin
                    modelQ.push_back({32'h0, 1'b1});
                end else if (we) begin
                    mWord = mm.exists(mIdx) ? mm[mIdx] : 32'hxxxx_xxxx;
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) mWord[8*i +: 8] = wdata[8*i +: 8];
                    end
                    mm[mIdx] = mWord;
                    modelQ.push_back({32'h0, 1'b0});
                end else begin
                    modelQ.push_back({mm[mIdx], 1'b0});
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("gnt", 32'(gnt), 32'(req && !reset && !gnt_stall && (modelQ.size() < MAXO)));
        checkOutput("rvalid", 32'(rvalid), 32'(modelQ.size() != 0));
        checkOutput("outstanding", 32'(outstanding), 32'(modelQ.size()));
        if (modelQ.size() != 0) begin
            checkOutput("rdata", rdata, modelQ[0][32:1]);
            checkOutput("err", 32'(err), 32'(modelQ[0][0]));
        end
        if (!reset && rvalid && rready) obsQ.push_back({rdata, err});
    end

    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [3:0] b,
                                 input logic [31:0] d);
        int waited = 0;
        @(posedge clk);
        #1;
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        #1;
        while (!gnt && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!gnt) checkOutput("grant_timeout", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic checkRsp(input string name, input logic [31:0] expData, input logic expErr);
        @(negedge clk);
        checkOutput({name, "_rvalid"}, 32'(rvalid), 32'd1);
        checkOutput({name, "_rdata"}, rdata, expData);
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] fullAddr [5];
        logic [31:0] fullData [5];
        int grants;
        int k;

        reset = 1'b1; req = 1'b1; addr = 32'h10; we = 1'b0; be = 4'hF;
        wdata = '0; rready = 1'b0; gnt_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fullAddr[i] = 32'h20 + 32'(4 * i);
            fullData[i] = 32'hA000_0001 + 32'(i);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; req = 1'b0; rready = 1'b1;

        applyStimulus(32'h0, 1'b1, 4'hF, 32'hA5A5_0000);
        applyStimulus(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        checkRsp("wr_rsp", 32'h0, 1'b0);
        applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
        checkRsp("rd_rsp", 32'hDEAD_BEEF, 1'b0);

        applyStimulus(32'h10, 1'b1, 4'b0101, 32'h1122_3344);
        applyStimulus(32'h13, 1'b0, 4'hF, 32'h0);
        checkRsp("partial_rd", 32'hDE22_BE44, 1'b0);

        applyStimulus(32'h400, 1'b0, 4'hF, 32'h0);
        checkRsp("oor_rd", 32'h0, 1'b1);
        applyStimulus(32'h400, 1'b1, 4'hF, 32'h1234_5678);
        checkRsp("oor_wr", 32'h0, 1'b1);
        applyStimulus(32'h0, 1'b0, 4'hF, 32'h0);
        checkRsp("word0_kept", 32'hA5A5_0000, 1'b0);

        for (int i = 0; i < 5; i++) applyStimulus(fullAddr[i], 1'b1, 4'hF, fullData[i]);
        repeat (2) @(posedge clk);

        // Back-pressure: five reads against a four-deep queue with rready low.
        @(posedge clk);
        #1;
        obsQ.delete();
        rready = 1'b0; req = 1'b1; we = 1'b0; be = 4'hF;
        grants = 0; k = 0;
        for (int c = 0; c < 8; c++) begin
            addr = fullAddr[k];
            #1;
            if (gnt) begin
                grants++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        addr = fullAddr[k];
        #1;
        checkOutput("full_grants", 32'(grants), 32'd4);
        checkOutput("full_outstanding", 32'(outstanding), 32'd4);
        checkOutput("full_gnt_low", 32'(gnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("stable_rdata", rdata, 32'hA000_0001);
            checkOutput("stable_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        #1;
        checkOutput("full_gnt_low_with_rready", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        rready = 1'b0;
        #1;
        checkOutput("fifth_granted", 32'(gnt), 32'd1);
        checkOutput("after_pop_outstanding", 32'(outstanding), 32'd3);
        @(posedge clk);
        #1;
        req = 1'b0;
        rready = 1'b1;
        repeat (8) @(posedge clk);
        checkOutput("order_count", 32'(obsQ.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < obsQ.size()) checkOutput("order_data", obsQ[i][32:1], 32'hA000_0001 + 32'(i));
        end

        // Stall: requests held off while gnt_stall is high.
        #1;
        gnt_stall = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stall_gnt", 32'(gnt), 32'd0);
            @(posedge clk);
            #1;
        end
        gnt_stall = 1'b0; req = 1'b0;

        // Reset with responses pending; memory must survive it.
        rready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(32'h10, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("pending_outstanding", 32'(outstanding), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midreset_outstanding", 32'(outstanding), 32'd0);
        rready = 1'b1;
        applyStimulus(32'h10, 1'b0, 4'hF, 32'h0);
        checkRsp("mem_kept", 32'hDE22_BE44, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
